// File: rtl/mac_tx_stream_arbiter.sv
// Packet-level round-robin arbiter feeding the single MAC TX stream; a grant is held until tlast is accepted.
// Grant 1 cycle after request, then zero-latency pass-through; m_tready stalls reach only the granted requester.
module mac_tx_stream_arbiter #(
  parameter int N_PORTS   = 4,
  parameter int N_SYMBOLS = 8,
  parameter int W_SYMBOL  = 8,
  localparam int W_IDX    = $clog2(N_PORTS)
) (
  input  logic                                              i_clk,
  input  logic                                              i_reset,
  input  logic [N_PORTS-1:0]                                s_tvalid,
  input  logic [N_PORTS-1:0][N_SYMBOLS-1:0][W_SYMBOL-1:0]   s_tdata,
  input  logic [N_PORTS-1:0][N_SYMBOLS-1:0]                 s_tkeep,
  input  logic [N_PORTS-1:0]                                s_tlast,
  output logic [N_PORTS-1:0]                                s_tready,
  output logic                                              m_tvalid,
  output logic [N_SYMBOLS-1:0][W_SYMBOL-1:0]                m_tdata,
  output logic [N_SYMBOLS-1:0]                              m_tkeep,
  output logic                                              m_tlast,
  input  logic                                              m_tready,
  output logic                                              o_busy,
  output logic [W_IDX-1:0]                                  o_grant_idx,
  output logic                                              o_frame_done
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [W_IDX-1:0] rr_ptr;
  logic [W_IDX-1:0] grant_idx;
  logic [W_IDX-1:0] sel_idx;
  logic             sel_vld;
  logic             beat_acc;
  logic             last_acc;
  logic             frame_done;

  // base + off with off in 1..N_PORTS never exceeds 2*N_PORTS-1, so one subtract wraps it.
  function automatic logic [W_IDX-1:0] port_after(input logic [W_IDX-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= N_PORTS) begin
      sum = sum - N_PORTS;
    end
    return W_IDX'(sum);
  endfunction

  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    for (int i = 1; i <= N_PORTS; i++) begin
      if (!sel_vld && s_tvalid[port_after(rr_ptr, i)]) begin
        sel_vld = 1'b1;
        sel_idx = port_after(rr_ptr, i);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sel_vld)  state_nxt = BUSY;
      BUSY:    if (last_acc) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Idle drives zeros on every data lane so nothing undefined leaks to the MAC.
  always_comb begin
    s_tready = '0;
    m_tvalid = 1'b0;
    m_tdata  = '0;
    m_tkeep  = '0;
    m_tlast  = 1'b0;
    o_busy   = 1'b0;
    if (state == BUSY) begin
      o_busy              = 1'b1;
      m_tvalid            = s_tvalid[grant_idx];
      m_tdata             = s_tdata[grant_idx];
      m_tkeep             = s_tkeep[grant_idx];
      m_tlast             = s_tlast[grant_idx];
      s_tready[grant_idx] = m_tready;
    end
  end

  assign beat_acc = (state == BUSY) && m_tvalid && m_tready;
  assign last_acc = beat_acc && m_tlast;

  // The pointer only advances on a grant, so an idle link keeps the previous winner as the scan origin.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rr_ptr     <= W_IDX'(N_PORTS - 1);
      grant_idx  <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= last_acc;
      if ((state == IDLE) && sel_vld) begin
        grant_idx <= sel_idx;
        rr_ptr    <= sel_idx;
      end
    end
  end

  assign o_grant_idx  = grant_idx;
  assign o_frame_done = frame_done;

  a_ready_onehot: assert property (@(posedge i_clk) disable iff (i_reset) $onehot0(s_tready));
  a_valid_busy:   assert property (@(posedge i_clk) disable iff (i_reset) m_tvalid |-> o_busy);

endmodule

// File: tb/tb_mac_tx_stream_arbiter.sv
// Bench for mac_tx_stream_arbiter: vector table, directed multi-cycle sequences, and randomized traffic
// checked against a frame-level round-robin model; a 3-port instance covers the non-power-of-2 wrap.
module tb_mac_tx_stream_arbiter;
  localparam int N  = 4;
  localparam int N3 = 3;
  localparam int NS = 2;
  localparam int WS = 8;

  logic clk = 1'b0;
  logic i_reset;

  logic [N-1:0]                 s_tvalid, s_tlast, s_tready;
  logic [N-1:0][NS-1:0][WS-1:0] s_tdata;
  logic [N-1:0][NS-1:0]         s_tkeep;
  logic                         m_tvalid, m_tlast, m_tready;
  logic [NS-1:0][WS-1:0]        m_tdata;
  logic [NS-1:0]                m_tkeep;
  logic                         o_busy, o_frame_done;
  logic [1:0]                   o_grant_idx;

  logic [N3-1:0]                 t_v, t_l, t_rdy;
  logic [N3-1:0][NS-1:0][WS-1:0] t_d;
  logic [N3-1:0][NS-1:0]         t_k;
  logic                          t_mv, t_ml, t_r;
  logic [NS-1:0][WS-1:0]         t_md;
  logic [NS-1:0]                 t_mk;
  logic                          t_busy, t_done;
  logic [1:0]                    t_g;

  int n_cmp = 0;
  int n_err = 0;

  mac_tx_stream_arbiter #(.N_PORTS(N), .N_SYMBOLS(NS), .W_SYMBOL(WS)) dut (
    .i_clk(clk), .i_reset(i_reset),
    .s_tvalid(s_tvalid), .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tlast(s_tlast), .s_tready(s_tready),
    .m_tvalid(m_tvalid), .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast), .m_tready(m_tready),
    .o_busy(o_busy), .o_grant_idx(o_grant_idx), .o_frame_done(o_frame_done)
  );

  mac_tx_stream_arbiter #(.N_PORTS(N3), .N_SYMBOLS(NS), .W_SYMBOL(WS)) dut3 (
    .i_clk(clk), .i_reset(i_reset),
    .s_tvalid(t_v), .s_tdata(t_d), .s_tkeep(t_k), .s_tlast(t_l), .s_tready(t_rdy),
    .m_tvalid(t_mv), .m_tdata(t_md), .m_tkeep(t_mk), .m_tlast(t_ml), .m_tready(t_r),
    .o_busy(t_busy), .o_grant_idx(t_g), .o_frame_done(t_done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0] v;
    logic [3:0] l;
    logic       r;
    logic       busy;
    int         g;
    logic       mval;
    logic [3:0] srdy;
    logic       mlast;
    logic       done;
    int         dp;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [15:0] dat_of(input int p);
    return 16'hA050 + 16'(p) * 16'h0101;
  endfunction

  function automatic logic [1:0] keep_of(input int p);
    return (p % 2 == 1) ? 2'b11 : 2'b10;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic eb, input int eg, input logic emv,
                           input logic [3:0] esr, input logic eml, input logic ed,
                           input logic [15:0] edat, input logic [1:0] ekeep);
    chk({tag, ".busy"},  32'(o_busy),       32'(eb));
    chk({tag, ".grant"}, 32'(o_grant_idx),  32'(eg));
    chk({tag, ".mval"},  32'(m_tvalid),     32'(emv));
    chk({tag, ".srdy"},  32'(s_tready),     32'(esr));
    chk({tag, ".mlast"}, 32'(m_tlast),      32'(eml));
    chk({tag, ".done"},  32'(o_frame_done), 32'(ed));
    chk({tag, ".mdat"},  32'(m_tdata),      32'(edat));
    chk({tag, ".mkeep"}, 32'(m_tkeep),      32'(ekeep));
  endtask

  task automatic do_reset();
    @(negedge clk);
    i_reset  = 1'b1;
    s_tvalid = '0;
    s_tlast  = '0;
    m_tready = 1'b0;
    t_v      = '0;
    t_l      = '0;
    t_r      = 1'b0;
    repeat (2) @(negedge clk);
    i_reset = 1'b0;
    #1;
    check_all("reset", 1'b0, 0, 1'b0, 4'b0000, 1'b0, 1'b0, 16'h0, 2'b00);
    chk("reset.t_busy", 32'(t_busy), 32'd0);
    chk("reset.t_srdy", 32'(t_rdy),  32'd0);
    chk("reset.t_mval", 32'(t_mv),   32'd0);
  endtask

  initial begin
    int   bc[N];
    int   owner, last_win, exp_g;
    logic exp_done, acc;
    int   seq[N], left[N];
    logic eb;
    int   eg;

    i_reset  = 1'b1;
    s_tvalid = '0;
    s_tlast  = '0;
    m_tready = 1'b0;
    t_v      = '0;
    t_l      = '0;
    t_r      = 1'b0;
    for (int p = 0; p < N; p++) begin
      s_tdata[p] = dat_of(p);
      s_tkeep[p] = keep_of(p);
    end
    for (int p = 0; p < N3; p++) begin
      t_d[p] = dat_of(p);
      t_k[p] = keep_of(p);
    end

    // v, l, r, busy, g, mval, srdy, mlast, done, data port (4 = zeros)
    tbl.push_back('{4'b0001, 4'b0000, 1'b1, 1'b0, 0, 1'b0, 4'b0000, 1'b0, 1'b0, 4});
    tbl.push_back('{4'b0001, 4'b0000, 1'b1, 1'b1, 0, 1'b1, 4'b0001, 1'b0, 1'b0, 0});
    tbl.push_back('{4'b0001, 4'b0000, 1'b1, 1'b1, 0, 1'b1, 4'b0001, 1'b0, 1'b0, 0});
    tbl.push_back('{4'b0001, 4'b0001, 1'b1, 1'b1, 0, 1'b1, 4'b0001, 1'b1, 1'b0, 0});
    tbl.push_back('{4'b0000, 4'b0000, 1'b1, 1'b0, 0, 1'b0, 4'b0000, 1'b0, 1'b1, 4});
    tbl.push_back('{4'b0000, 4'b0000, 1'b1, 1'b0, 0, 1'b0, 4'b0000, 1'b0, 1'b0, 4});
    tbl.push_back('{4'b1010, 4'b0000, 1'b1, 1'b0, 0, 1'b0, 4'b0000, 1'b0, 1'b0, 4});
    tbl.push_back('{4'b1010, 4'b0000, 1'b1, 1'b1, 1, 1'b1, 4'b0010, 1'b0, 1'b0, 1});
    tbl.push_back('{4'b1000, 4'b0000, 1'b1, 1'b1, 1, 1'b0, 4'b0010, 1'b0, 1'b0, 1});
    tbl.push_back('{4'b1010, 4'b0010, 1'b1, 1'b1, 1, 1'b1, 4'b0010, 1'b1, 1'b0, 1});
    tbl.push_back('{4'b1000, 4'b0000, 1'b1, 1'b0, 1, 1'b0, 4'b0000, 1'b0, 1'b1, 4});
    tbl.push_back('{4'b1000, 4'b1000, 1'b0, 1'b1, 3, 1'b1, 4'b0000, 1'b1, 1'b0, 3});
    tbl.push_back('{4'b1000, 4'b1000, 1'b1, 1'b1, 3, 1'b1, 4'b1000, 1'b1, 1'b0, 3});
    tbl.push_back('{4'b0100, 4'b0000, 1'b1, 1'b0, 3, 1'b0, 4'b0000, 1'b0, 1'b1, 4});
    tbl.push_back('{4'b0100, 4'b0000, 1'b1, 1'b1, 2, 1'b1, 4'b0100, 1'b0, 1'b0, 2});
    tbl.push_back('{4'b0100, 4'b0000, 1'b0, 1'b1, 2, 1'b1, 4'b0000, 1'b0, 1'b0, 2});
    tbl.push_back('{4'b0100, 4'b0100, 1'b1, 1'b1, 2, 1'b1, 4'b0100, 1'b1, 1'b0, 2});
    tbl.push_back('{4'b0000, 4'b0000, 1'b1, 1'b0, 2, 1'b0, 4'b0000, 1'b0, 1'b1, 4});

    do_reset();
    foreach (tbl[i]) begin
      @(negedge clk);
      s_tvalid = tbl[i].v;
      s_tlast  = tbl[i].l;
      m_tready = tbl[i].r;
      #1;
      check_all($sformatf("vec%0d", i), tbl[i].busy, tbl[i].g, tbl[i].mval, tbl[i].srdy,
                tbl[i].mlast, tbl[i].done,
                (tbl[i].dp < N) ? dat_of(tbl[i].dp) : 16'h0,
                (tbl[i].dp < N) ? keep_of(tbl[i].dp) : 2'b00);
    end

    // All ports hold 2-beat frames: one bubble after each frame, grants 0,1,2,3,0.
    do_reset();
    for (int p = 0; p < N; p++) bc[p] = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      s_tvalid = 4'hF;
      m_tready = 1'b1;
      for (int p = 0; p < N; p++) s_tlast[p] = (bc[p] == 1);
      #1;
      eb = ((c % 3) != 0);
      chk($sformatf("rr%0d.busy", c), 32'(o_busy), 32'(eb));
      if (eb) begin
        eg = (c / 3) % N;
        chk($sformatf("rr%0d.grant", c), 32'(o_grant_idx), 32'(eg));
        chk($sformatf("rr%0d.mlast", c), 32'(m_tlast), 32'((c % 3) == 2));
        bc[eg] = bc[eg] ^ 1;
      end else begin
        chk($sformatf("rr%0d.done", c), 32'(o_frame_done), 32'(c > 0));
      end
    end

    // Reset during beat 2 of a frame from port 1; afterwards port 0 wins.
    do_reset();
    for (int p = 0; p < N; p++) s_tdata[p] = dat_of(p);
    @(negedge clk);
    s_tvalid = 4'b0010;
    s_tlast  = 4'b0000;
    m_tready = 1'b1;
    #1;
    chk("mid.idle.busy", 32'(o_busy), 32'd0);
    @(negedge clk);
    #1;
    check_all("mid.beat1", 1'b1, 1, 1'b1, 4'b0010, 1'b0, 1'b0, dat_of(1), keep_of(1));
    @(negedge clk);
    i_reset = 1'b1;
    #1;
    chk("mid.beat2.busy", 32'(o_busy), 32'd1);
    @(negedge clk);
    i_reset  = 1'b0;
    s_tvalid = 4'b1111;
    #1;
    check_all("mid.after", 1'b0, 0, 1'b0, 4'b0000, 1'b0, 1'b0, 16'h0, 2'b00);
    @(negedge clk);
    #1;
    check_all("mid.regrant", 1'b1, 0, 1'b1, 4'b0001, 1'b0, 1'b0, dat_of(0), keep_of(0));

    // Three ports: port 2 alone is re-granted, then the pointer wraps 2 -> 0 -> 1 -> 2 -> 0.
    do_reset();
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      t_v = (c < 6) ? 3'b100 : 3'b111;
      t_l = 3'b111;
      t_r = 1'b1;
      #1;
      eb = ((c % 2) == 1);
      chk($sformatf("p3_%0d.busy", c), 32'(t_busy), 32'(eb));
      if (eb) begin
        eg = (c < 6) ? 2 : ((c - 7) / 2) % N3;
        chk($sformatf("p3_%0d.grant", c), 32'(t_g),   32'(eg));
        chk($sformatf("p3_%0d.mval", c),  32'(t_mv),  32'd1);
        chk($sformatf("p3_%0d.srdy", c),  32'(t_rdy), 32'(3'b001 << eg));
      end else begin
        chk($sformatf("p3_%0d.mval", c), 32'(t_mv),   32'd0);
        chk($sformatf("p3_%0d.srdy", c), 32'(t_rdy),  32'd0);
        chk($sformatf("p3_%0d.done", c), 32'(t_done), 32'(c > 0));
      end
    end

    // Random traffic against a frame-level model: owner of the link, last winner, pending done pulse.
    do_reset();
    owner    = -1;
    last_win = N - 1;
    exp_g    = 0;
    exp_done = 1'b0;
    for (int p = 0; p < N; p++) begin
      seq[p]  = 0;
      left[p] = $urandom_range(1, 4);
    end
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      for (int p = 0; p < N; p++) begin
        s_tvalid[p] = ($urandom_range(0, 3) != 0);
        s_tlast[p]  = (left[p] == 1);
        s_tdata[p]  = 16'((p << 12) | (seq[p] & 'hfff));
        s_tkeep[p]  = s_tlast[p] ? 2'b01 : 2'b11;
      end
      m_tready = ($urandom_range(0, 9) < 7);
      #1;
      if (owner < 0) begin
        check_all("rnd", 1'b0, exp_g, 1'b0, 4'b0000, 1'b0, exp_done, 16'h0, 2'b00);
      end else begin
        check_all("rnd", 1'b1, owner, s_tvalid[owner], 4'(m_tready) << owner, s_tlast[owner],
                  exp_done, s_tdata[owner], s_tkeep[owner]);
      end
      acc      = (owner >= 0) && s_tvalid[owner] && m_tready;
      exp_done = acc && s_tlast[owner];
      if (acc) begin
        seq[owner]++;
        left[owner]--;
        if (left[owner] == 0) left[owner] = $urandom_range(1, 4);
      end
      if (owner < 0) begin
        for (int off = 1; off <= N; off++) begin
          if (s_tvalid[(last_win + off) % N]) begin
            owner    = (last_win + off) % N;
            last_win = owner;
            exp_g    = owner;
            break;
          end
        end
      end else if (exp_done) begin
        owner = -1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
